led_fade_sequencer: RTL and testbench
=====================================

Name: led_fade_sequencer

Overview:
Brightness sequencer for the exponential LED PWM core. Produces the linear brightness code that the exp-PWM datapath converts to duty cycle. Supports hold, ramp-to-target, breathe and blink modes. Level changes are paced by the PWM core's end-of-period pulse, so duty never changes mid-period.

Parameters:
LEVEL_W, 8, width of brightness code and target
DIV_W, 8, width of step-rate prescaler (PWM periods per step, minus one)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
ena  in  1  design enable; low freezes all state
mode  in  2  00 hold, 01 ramp-to-target, 10 breathe, 11 blink
target  in  LEVEL_W  ramp destination / breathe ceiling / blink on-level
rate  in  DIV_W  step every rate+1 PWM periods
period_done  in  1  one-cycle pulse from PWM core at end of each PWM period
level  out  LEVEL_W  brightness code to exp-PWM core (registered)
busy  out  1  high while level is moving (RAMP, BREATHE, BLINK states)
at_target  out  1  one-cycle pulse when ramp lands on target
dir  out  1  current step direction, 1 = up

Behaviour:
- Reset (rst_n low at posedge): state HOLD, level 0, busy 0, at_target 0, dir 1, prescaler 0. Reset mid-ramp takes effect on that edge; no residual step.
- ena low: state, prescaler, level and dir held; at_target forced 0. Resumes exactly where frozen.
- Prescaler: on period_done, if cnt == rate then tick, cnt <= 0; else cnt <= cnt+1. rate=0 -> tick every period. Change of mode clears cnt.
- Latency: level updates on the clock edge that samples period_done with tick; new level visible the cycle after the period_done pulse.
- States: HOLD, RAMP, BRTH_UP, BRTH_DN, BLINK. Mode decode each cycle:
  - mode 00 -> HOLD: level frozen, busy 0.
  - mode 01: if level != target -> RAMP, else HOLD. On each tick in RAMP: level +/-1 toward current target (dir recomputed every tick, so target changes mid-ramp are followed). On step that makes level == target: at_target pulse same edge, state HOLD. While HOLD with mode 01 and target changes away from level -> RAMP next cycle. Entering mode 01 with level == target: at_target pulses once on the next edge, no step.
  - mode 10: enter BRTH_UP if level < target, else BRTH_DN. Tick in BRTH_UP: level+1; when level reaches target, next state BRTH_DN (dir 0). Tick in BRTH_DN: level-1; on reaching 0 -> BRTH_UP. Target 0: level driven to 0 and held. Level above a lowered target: descends in BRTH_DN.
  - mode 11 BLINK: on each tick level toggles between 0 and target (nonzero level -> 0, 0 -> target). Entry does not modify level.
- Arithmetic: level never wraps; steps clamp at 0 and 2^LEVEL_W-1.
- busy = 1 in RAMP, BRTH_UP, BRTH_DN, BLINK; 0 in HOLD.
- period_done and mode change in same cycle: mode change wins; no step that cycle, cnt cleared.
- at_target only in mode 01; never asserted in breathe/blink.

Test Plan:
- Reset then mode=01, target=5, rate=0, period_done every 4 cycles -> level 1,2,3,4,5 one cycle after each pulse; at_target pulses with level=5; busy falls; further pulses leave level 5.
- rate=2, mode=01, target=2 from 0 -> level steps only on every 3rd period_done (3rd and 6th); at_target on 6th.
- mode=10, target=3, rate=0 -> level 1,2,3,2,1,0,1,... ; dir flips at 3 and 0; at_target never asserts.
- Ramp 0->200 then target changed to 10 at level 50 -> level decreases 49,48,...,10, dir 0, at_target at 10.
- ena low for 20 cycles with period_done pulsing mid-ramp at level 7 -> level stays 7, cnt frozen; after ena high resumes at 8 on next tick.
- rst_n low for one edge mid-breathe at level 6 -> level 0, busy 0, dir 1, state HOLD next cycle; mode=11, target=9 -> blink 9,0,9 per tick.

Source files
------------

// File: rtl/led_fade_sequencer.sv
// led_fade_sequencer
//   Brightness sequencer for the exponential LED PWM core. It produces the
//   linear brightness code that the exp-PWM datapath turns into a duty cycle.
//   Modes are hold, ramp-to-target, breathe and blink. Level changes happen
//   only on a prescaled PWM end-of-period pulse, so the duty cycle never
//   changes partway through a period.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   ena          design enable; low freezes all state, at_target forced 0
//   mode         00 hold, 01 ramp-to-target, 10 breathe, 11 blink
//   target       ramp destination / breathe ceiling / blink on-level
//   rate         one step every rate+1 PWM periods
//   period_done  one-cycle pulse from the PWM core at each period end
//   level        registered brightness code to the exp-PWM core
//   busy         high while level is moving (RAMP, BRTH_UP, BRTH_DN, BLINK)
//   at_target    one-cycle pulse when a ramp lands on target
//   dir          current step direction, 1 = up
module led_fade_sequencer #(
    parameter int LEVEL_W = 8,
    parameter int DIV_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [1:0]         mode,
    input  logic [LEVEL_W-1:0] target,
    input  logic [DIV_W-1:0]   rate,
    input  logic               period_done,
    output logic [LEVEL_W-1:0] level,
    output logic               busy,
    output logic               at_target,
    output logic               dir
);

    typedef enum logic [2:0] {
        HOLD,
        RAMP,
        BRTH_UP,
        BRTH_DN,
        BLINK
    } state_t;

    localparam logic [LEVEL_W-1:0] LVL_MAX = '1;

    state_t             state;
    logic [1:0]         mode_q;
    logic [DIV_W-1:0]   cnt;
    logic               mode_chg;
    logic               tick;
    logic [LEVEL_W-1:0] lvl_inc;
    logic [LEVEL_W-1:0] lvl_dec;
    logic [LEVEL_W-1:0] ramp_nxt;

    // A mode change takes priority over a coincident period_done: the
    // prescaler restarts and no step is taken that cycle.
    assign mode_chg = (mode != mode_q);
    assign tick     = period_done && !mode_chg && (cnt == rate);

    // Saturating neighbours of the current level; the code never wraps.
    assign lvl_inc  = (level == LVL_MAX) ? level : level + 1'b1;
    assign lvl_dec  = (level == '0)      ? level : level - 1'b1;
    assign ramp_nxt = (target > level)   ? lvl_inc : lvl_dec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HOLD;
            level     <= '0;
            busy      <= 1'b0;
            at_target <= 1'b0;
            dir       <= 1'b1;
            cnt       <= '0;
            mode_q    <= 2'b00;
        end else if (!ena) begin
            at_target <= 1'b0;
        end else begin
            mode_q    <= mode;
            at_target <= 1'b0;

            if (mode_chg)
                cnt <= '0;
            else if (period_done)
                cnt <= (cnt == rate) ? '0 : cnt + 1'b1;

            case (mode)
                2'b00: begin
                    state <= HOLD;
                    busy  <= 1'b0;
                end

                2'b01: begin
                    // Direction is recomputed every step so a target moved
                    // mid-ramp is simply chased from the current level.
                    if (tick && state == RAMP && level != target) begin
                        level <= ramp_nxt;
                        dir   <= (target > level);
                        if (ramp_nxt == target) begin
                            at_target <= 1'b1;
                            state     <= HOLD;
                            busy      <= 1'b0;
                        end else begin
                            state <= RAMP;
                            busy  <= 1'b1;
                        end
                    end else if (level != target) begin
                        state <= RAMP;
                        busy  <= 1'b1;
                        dir   <= (target > level);
                    end else begin
                        // Already there: only announce it on entry to the mode.
                        state     <= HOLD;
                        busy      <= 1'b0;
                        at_target <= mode_chg;
                    end
                end

                2'b10: begin
                    busy <= 1'b1;
                    if (mode_chg) begin
                        if (level < target) begin
                            state <= BRTH_UP;
                            dir   <= 1'b1;
                        end else begin
                            state <= BRTH_DN;
                            dir   <= 1'b0;
                        end
                    end else if (tick) begin
                        if (target == '0) begin
                            // Zero ceiling: pull down to 0 and park there.
                            level <= lvl_dec;
                            state <= BRTH_DN;
                            dir   <= 1'b0;
                        end else if (state == BRTH_UP && level < target) begin
                            level <= lvl_inc;
                            if (lvl_inc == target) begin
                                state <= BRTH_DN;
                                dir   <= 1'b0;
                            end
                        end else if (level != '0) begin
                            // Covers normal descent and a ceiling lowered
                            // below the current level.
                            level <= lvl_dec;
                            if (lvl_dec == '0) begin
                                state <= BRTH_UP;
                                dir   <= 1'b1;
                            end else begin
                                state <= BRTH_DN;
                                dir   <= 1'b0;
                            end
                        end else begin
                            state <= BRTH_UP;
                            dir   <= 1'b1;
                        end
                    end
                end

                2'b11: begin
                    busy  <= 1'b1;
                    state <= BLINK;
                    if (tick && state == BLINK)
                        level <= (level != '0) ? '0 : target;
                end

                default: begin
                    state <= HOLD;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_fade_sequencer.sv
// tb_led_fade_sequencer
//   Directed scenarios plus a randomized run for led_fade_sequencer, checked
//   against a behavioural model of the sequencing rules kept in this file.
module tb_led_fade_sequencer;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [1:0] mode;
    logic [7:0] target;
    logic [7:0] rate;
    logic       period_done;
    logic [7:0] level;
    logic       busy;
    logic       at_target;
    logic       dir;

    int errors = 0;
    int checks = 0;

    led_fade_sequencer #(.LEVEL_W(8), .DIV_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .target(target),
        .rate(rate), .period_done(period_done), .level(level), .busy(busy),
        .at_target(at_target), .dir(dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_RAMP = 1, P_UP = 2, P_DOWN = 3, P_BLINK = 4;
    int         m_phase;
    logic [7:0] m_level;
    logic [7:0] m_cnt;
    logic [1:0] m_pmode;
    logic       m_dir, m_busy, m_at;

    // Applies one clock edge of behaviour using the inputs currently driven.
    task automatic model_edge();
        logic chg, tk;
        int   gap;
        if (!rst_n) begin
            m_phase = P_IDLE; m_level = 0; m_cnt = 0; m_pmode = 0;
            m_dir = 1; m_busy = 0; m_at = 0;
            return;
        end
        if (!ena) begin
            m_at = 0;
            return;
        end
        chg = (mode != m_pmode);
        tk  = period_done && !chg && (m_cnt == rate);
        if (chg) m_cnt = 0;
        else if (period_done) m_cnt = (m_cnt == rate) ? 8'd0 : m_cnt + 8'd1;
        m_pmode = mode;
        m_at    = 0;
        gap     = int'(target) - int'(m_level);
        case (mode)
            2'd0: m_phase = P_IDLE;
            2'd1: begin
                if (gap == 0) begin
                    if (m_phase != P_RAMP || !tk) m_at = chg;
                    m_phase = P_IDLE;
                end else if (tk && m_phase == P_RAMP) begin
                    m_dir   = (gap > 0);
                    m_level = 8'(int'(m_level) + ((gap > 0) ? 1 : -1));
                    if (m_level == target) begin
                        m_at = 1; m_phase = P_IDLE;
                    end
                end else begin
                    m_phase = P_RAMP; m_dir = (gap > 0);
                end
            end
            2'd2: begin
                if (chg) begin
                    m_phase = (gap > 0) ? P_UP : P_DOWN;
                    m_dir   = (gap > 0);
                end else if (tk) begin
                    if (target == 0) begin
                        if (m_level > 0) m_level = m_level - 1;
                        m_phase = P_DOWN; m_dir = 0;
                    end else if (m_phase == P_UP && gap > 0) begin
                        m_level = m_level + 1;
                        if (m_level == target) begin m_phase = P_DOWN; m_dir = 0; end
                    end else if (m_level > 0) begin
                        m_level = m_level - 1;
                        m_phase = (m_level == 0) ? P_UP : P_DOWN;
                        m_dir   = (m_level == 0);
                    end else begin
                        m_phase = P_UP; m_dir = 1;
                    end
                end
            end
            default: begin
                m_phase = P_BLINK;
                if (tk) m_level = (m_level == 0) ? target : 8'd0;
            end
        endcase
        m_busy = (m_phase != P_IDLE);
    endtask

    // One clock: model and DUT see the same inputs; sample #1 after the edge.
    task automatic tick_clk();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        period_done = 1'b1;
        tick_clk();
        period_done = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ena = 1'b1; mode = 2'b00; target = 8'd0; rate = 8'd0;
        period_done = 1'b0;
        tick_clk();
        tick_clk();
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({level, busy, at_target, dir} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset: level=%0d busy=%0b at=%0b dir=%0b, want 0 0 0 1",
                     level, busy, at_target, dir);
        end
    endtask

    task automatic test_ramp();
        do_reset();
        mode = 2'b01; target = 8'd5; rate = 8'd0;
        tick_clk();
        checks++;
        if (busy !== 1'b1 || level !== 8'd0) begin
            errors++; $display("FAIL ramp_entry: busy=%0b level=%0d, want 1 0", busy, level);
        end
        for (int i = 1; i <= 6; i++) begin
            repeat (3) tick_clk();
            pulse();
            checks++;
            if (level !== 8'((i > 5) ? 5 : i)) begin
                errors++; $display("FAIL ramp_level: step %0d got %0d want %0d", i, level, (i > 5) ? 5 : i);
            end
            checks++;
            if (at_target !== (i == 5) || busy !== (i < 5)) begin
                errors++; $display("FAIL ramp_flags: step %0d at=%0b busy=%0b", i, at_target, busy);
            end
        end
        // Re-entering ramp mode already on target announces it once.
        mode = 2'b00; tick_clk();
        mode = 2'b01; tick_clk();
        checks++;
        if (at_target !== 1'b1 || busy !== 1'b0 || level !== 8'd5) begin
            errors++; $display("FAIL ramp_reentry: at=%0b busy=%0b level=%0d, want 1 0 5", at_target, busy, level);
        end
        tick_clk();
        checks++;
        if (at_target !== 1'b0) begin
            errors++; $display("FAIL ramp_reentry_once: at=%0b want 0", at_target);
        end
    endtask

    task automatic test_prescaler();
        do_reset();
        mode = 2'b01; target = 8'd2; rate = 8'd2;
        tick_clk();
        for (int p = 1; p <= 6; p++) begin
            tick_clk();
            pulse();
            checks++;
            if (level !== 8'((p < 3) ? 0 : (p < 6) ? 1 : 2) || at_target !== (p == 6)) begin
                errors++; $display("FAIL prescale: pulse %0d level=%0d at=%0b", p, level, at_target);
            end
        end
    endtask

    task automatic test_breathe();
        logic [7:0] exp_l [8] = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1, 8'd2};
        logic       exp_d [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        mode = 2'b10; target = 8'd3; rate = 8'd0;
        tick_clk();
        for (int i = 0; i < 8; i++) begin
            tick_clk();
            pulse();
            checks++;
            if (level !== exp_l[i] || dir !== exp_d[i] || at_target !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL breathe: step %0d level=%0d dir=%0b at=%0b, want level=%0d dir=%0b at=0",
                         i, level, dir, at_target, exp_l[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_retarget();
        do_reset();
        mode = 2'b01; target = 8'd200; rate = 8'd0;
        tick_clk();
        repeat (50) begin pulse(); tick_clk(); end
        checks++;
        if (level !== 8'd50 || dir !== 1'b1) begin
            errors++; $display("FAIL retarget_up: level=%0d dir=%0b, want 50 1", level, dir);
        end
        target = 8'd10;
        tick_clk();
        for (int v = 49; v >= 10; v--) begin
            pulse();
            checks++;
            if (level !== 8'(v) || dir !== 1'b0 || at_target !== (v == 10)) begin
                errors++; $display("FAIL retarget_down: level=%0d dir=%0b at=%0b, want %0d 0 %0b",
                                   level, dir, at_target, v, v == 10);
            end
            tick_clk();
        end
    endtask

    task automatic test_enable_freeze();
        do_reset();
        mode = 2'b01; target = 8'd20; rate = 8'd1;
        tick_clk();
        repeat (15) begin pulse(); tick_clk(); end   // 7 steps, one period pending
        checks++;
        if (level !== 8'd7) begin
            errors++; $display("FAIL freeze_setup: level=%0d want 7", level);
        end
        ena = 1'b0;
        for (int i = 0; i < 20; i++) begin
            period_done = (i % 2 == 0);
            tick_clk();
            checks++;
            if (level !== 8'd7 || at_target !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL freeze_hold: cycle %0d level=%0d at=%0b busy=%0b", i, level, at_target, busy);
            end
        end
        period_done = 1'b0;
        ena = 1'b1;
        tick_clk();
        pulse();
        checks++;
        if (level !== 8'd8) begin
            errors++; $display("FAIL freeze_resume: level=%0d want 8", level);
        end
    endtask

    task automatic test_mode_change_wins();
        do_reset();
        mode = 2'b01; target = 8'd5; rate = 8'd0;
        tick_clk();
        pulse();
        mode = 2'b00; period_done = 1'b1; tick_clk();
        checks++;
        if (level !== 8'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL modechg_hold: level=%0d busy=%0b, want 1 0", level, busy);
        end
        mode = 2'b01; tick_clk();
        checks++;
        if (level !== 8'd1 || busy !== 1'b1) begin
            errors++; $display("FAIL modechg_ramp: level=%0d busy=%0b, want 1 1", level, busy);
        end
        pulse();
        checks++;
        if (level !== 8'd2) begin
            errors++; $display("FAIL modechg_resume: level=%0d want 2", level);
        end
    endtask

    task automatic test_reset_then_blink();
        do_reset();
        mode = 2'b10; target = 8'd10; rate = 8'd0;
        tick_clk();
        repeat (6) begin pulse(); tick_clk(); end
        rst_n = 1'b0;
        tick_clk();
        rst_n = 1'b1;
        checks++;
        if ({level, busy, at_target, dir} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL midreset: level=%0d busy=%0b dir=%0b, want 0 0 1", level, busy, dir);
        end
        mode = 2'b11; target = 8'd9;
        tick_clk();
        for (int i = 0; i < 3; i++) begin
            tick_clk();
            pulse();
            checks++;
            if (level !== ((i % 2 == 0) ? 8'd9 : 8'd0) || busy !== 1'b1 || at_target !== 1'b0) begin
                errors++; $display("FAIL blink: step %0d level=%0d busy=%0b at=%0b", i, level, busy, at_target);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            ena = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0)
                target = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
            if ($urandom_range(0, 99) == 0) rate = 8'($urandom_range(0, 3));
            period_done = ($urandom_range(0, 2) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            tick_clk();
            checks++;
            if ({level, busy, at_target, dir} !== {m_level, m_busy, m_at, m_dir}) begin
                errors++;
                $display("FAIL random: cycle %0d got level=%0d busy=%0b at=%0b dir=%0b want %0d %0b %0b %0b",
                         i, level, busy, at_target, dir, m_level, m_busy, m_at, m_dir);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_prescaler();
        test_breathe();
        test_retarget();
        test_enable_freeze();
        test_mode_change_wins();
        test_reset_then_blink();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
